// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   FWD_*      : EX operand forwarding select encodings
//   HZ_*       : hazard/halt FSM state encoding
//   REG_ZERO   : architectural zero register, never forwarded or hazarded
//   wb_src_t   : one pipeline register's write-back destination (we + rd)
package pipe_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    HZ_RUN    = 2'b00,
    HZ_DRAIN  = 2'b01,
    HZ_HALTED = 2'b10
  } hz_state_e;

  typedef struct packed {
    logic       we;
    logic [4:0] wa;
  } wb_src_t;

  // True when a write-back source produces the register being read.
  function automatic logic wb_hit(input wb_src_t s, input logic [4:0] ra);
    return s.we && (s.wa != REG_ZERO) && (s.wa == ra);
  endfunction

endpackage

// File: rtl/pipe_fwd_unit.sv
// Combinational EX-stage forwarding selects for NUM_PORTS source operands.
//   ra    : source register of each EX operand (from ID/EX)
//   exmem : EX/MEM write-back destination
//   memwb : MEM/WB write-back destination
//   fwd   : per-operand select, EX/MEM wins over MEM/WB (newer result)
module pipe_fwd_unit
  import pipe_pkg::*;
#(
  parameter int NUM_PORTS = 2
) (
  input  logic    [NUM_PORTS-1:0][4:0] ra,
  input  wb_src_t                      exmem,
  input  wb_src_t                      memwb,
  output logic    [NUM_PORTS-1:0][1:0] fwd
);

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    always_comb begin
      fwd[p] = FWD_RF;
      if (wb_hit(exmem, ra[p]))      fwd[p] = FWD_EXMEM;
      else if (wb_hit(memwb, ra[p])) fwd[p] = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and halt-drain controller for the 5-stage pipeline.
// Inputs : ID source regs/uses, ID/EX rs1/rs2/rd/we/load, HALT_IDEX,
//          REDIRECT_EX, EX/MEM and MEM/WB rd/we.
// Outputs: PC_WEN, IFID_WEN, IFID_FLUSH, IDEX_BUBBLE, FWD_A/FWD_B,
//          HALT_OUT (sticky), STALL_CNT / FLUSH_CNT (saturating).
// While RSTn is low every control output is forced to its safe value
// (no fetch, NOP in IF/ID, bubble in ID/EX, no forwarding).
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [4:0]       RA1_ID,
  input  logic [4:0]       RA2_ID,
  input  logic             USE_RA1_ID,
  input  logic             USE_RA2_ID,
  input  logic [4:0]       RA1_IDEX,
  input  logic [4:0]       RA2_IDEX,
  input  logic [4:0]       WA_IDEX,
  input  logic             RF_WE_IDEX,
  input  logic             isLoad_IDEX,
  input  logic             HALT_IDEX,
  input  logic             REDIRECT_EX,
  input  logic [4:0]       WA_EXMEM,
  input  logic             RF_WE_EXMEM,
  input  logic [4:0]       WA_MEMWB,
  input  logic             RF_WE_MEMWB,
  output logic             PC_WEN,
  output logic             IFID_WEN,
  output logic             IFID_FLUSH,
  output logic             IDEX_BUBBLE,
  output logic [1:0]       FWD_A,
  output logic [1:0]       FWD_B,
  output logic             HALT_OUT,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic [CNT_W-1:0] FLUSH_CNT
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LD = DW'(DRAIN_CYCLES - 1);

  // ---------------- forwarding ----------------
  logic [1:0][4:0] fwd_ra;
  logic [1:0][1:0] fwd_sel;
  wb_src_t         exmem_src, memwb_src;

  assign fwd_ra    = {RA2_IDEX, RA1_IDEX};
  assign exmem_src = '{we: RF_WE_EXMEM, wa: WA_EXMEM};
  assign memwb_src = '{we: RF_WE_MEMWB, wa: WA_MEMWB};

  pipe_fwd_unit #(.NUM_PORTS(2)) u_fwd (
    .ra    (fwd_ra),
    .exmem (exmem_src),
    .memwb (memwb_src),
    .fwd   (fwd_sel)
  );

  // ---------------- load-use detect ----------------
  logic lu;
  assign lu = isLoad_IDEX && RF_WE_IDEX && (WA_IDEX != REG_ZERO) &&
              ((USE_RA1_ID && (RA1_ID == WA_IDEX)) ||
               (USE_RA2_ID && (RA2_ID == WA_IDEX)));

  // ---------------- FSM + counters ----------------
  hz_state_e        state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic             halt_q, halt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             pc_wen, ifid_wen, ifid_flush, idex_bubble;

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    halt_d      = halt_q;
    stall_d     = stall_q;
    flush_d     = flush_q;
    pc_wen      = 1'b0;
    ifid_wen    = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b1;
    unique case (state_q)
      HZ_RUN: begin
        if (HALT_IDEX) begin
          drain_d = DRAIN_LD;
          if (DRAIN_CYCLES == 1) begin
            state_d = HZ_HALTED;
            halt_d  = 1'b1;
          end else begin
            state_d = HZ_DRAIN;
          end
        end else if (REDIRECT_EX) begin
          // Redirect wins over lu: the instruction we'd stall is wrong-path.
          pc_wen     = 1'b1;
          ifid_wen   = 1'b1;
          ifid_flush = 1'b1;
          if (flush_q != '1) flush_d = flush_q + CNT_W'(1);
        end else if (lu) begin
          // One-cycle stall: the load moves to MEM, after which MEM/WB forwarding covers it.
          if (stall_q != '1) stall_d = stall_q + CNT_W'(1);
        end else begin
          pc_wen      = 1'b1;
          ifid_wen    = 1'b1;
          idex_bubble = 1'b0;
        end
      end
      HZ_DRAIN: begin
        if (drain_q == '0) begin
          state_d = HZ_HALTED;
          halt_d  = 1'b1;
        end else begin
          drain_d = drain_q - DW'(1);
        end
      end
      HZ_HALTED: begin
      end
      default: state_d = HZ_RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= HZ_RUN;
      drain_q <= '0;
      halt_q  <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      halt_q  <= halt_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  // ---------------- outputs (forced safe while in reset) ----------------
  assign PC_WEN      = RSTn & pc_wen;
  assign IFID_WEN    = RSTn & ifid_wen;
  assign IFID_FLUSH  = ~RSTn | ifid_flush;
  assign IDEX_BUBBLE = ~RSTn | idex_bubble;
  assign FWD_A       = RSTn ? fwd_sel[0] : FWD_RF;
  assign FWD_B       = RSTn ? fwd_sel[1] : FWD_RF;
  assign HALT_OUT    = halt_q;
  assign STALL_CNT   = stall_q;
  assign FLUSH_CNT   = flush_q;

endmodule
